// File: rtl/score_pkg.sv
// Shared types and base-points table for the score event sequencer.
// Build option: SCORE_SOFTDROP_EN enables soft-drop point accumulation.
package score_pkg;

    localparam int DIGIT_W   = 5;
    localparam int LEVEL_W   = 4;
    localparam int MAX_LEVEL = 9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    // Lane [0] = ones .. lane [3] = thousands
    typedef bcd_digit_t [3:0] bcd_score_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } seq_state_t;

    // Base points per line count, BCD {th,hu,te,on}; entry 0 is unused
    localparam bcd_score_t BASE_PTS [0:4] = '{
        {DIGIT_W'(0), DIGIT_W'(0), DIGIT_W'(0), DIGIT_W'(0)},
        {DIGIT_W'(0), DIGIT_W'(0), DIGIT_W'(4), DIGIT_W'(0)},
        {DIGIT_W'(0), DIGIT_W'(1), DIGIT_W'(0), DIGIT_W'(0)},
        {DIGIT_W'(0), DIGIT_W'(3), DIGIT_W'(0), DIGIT_W'(0)},
        {DIGIT_W'(1), DIGIT_W'(2), DIGIT_W'(0), DIGIT_W'(0)}
    };

endpackage

// File: rtl/score_event_sequencer_lut.sv
// Line-count to base-points lookup with a validity flag.
// Line counts of 0 or above 4 report invalid and zero points.
module score_base_lut
    import score_pkg::*;
(
    input  logic [2:0]  lines_i,
    output bcd_score_t  points_o,
    output logic        valid_o
);

    // Decode the line count into its base BCD points
    always_comb begin
        points_o = '0;
        valid_o  = 1'b0;
        case (lines_i)
            3'd1: begin points_o = BASE_PTS[1]; valid_o = 1'b1; end
            3'd2: begin points_o = BASE_PTS[2]; valid_o = 1'b1; end
            3'd3: begin points_o = BASE_PTS[3]; valid_o = 1'b1; end
            3'd4: begin points_o = BASE_PTS[4]; valid_o = 1'b1; end
            default: begin points_o = '0; valid_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/score_event_sequencer.sv
// Turns line-clear events into per-cycle BCD increments, repeated level+1 times.
// Build option: SCORE_SOFTDROP_EN adds softdrop_pulse and a pending point counter.
module score_event_sequencer
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ev_valid,
    input  logic [2:0]         ev_lines,
    input  logic [LEVEL_W-1:0] level,
`ifdef SCORE_SOFTDROP_EN
    input  logic               softdrop_pulse,
`endif
    output logic               ev_ready,
    output bcd_score_t         score_to_add,
    output logic               busy,
    output logic               award_done
);

    seq_state_t         state_q;
    bcd_score_t         score_q;
    logic               busy_q;
    logic               done_q;
    logic [LEVEL_W-1:0] rep_q;
    logic [LEVEL_W-1:0] lvl_clamp;
    bcd_score_t         lut_pts;
    logic               lut_valid;
    logic               accept;
`ifdef SCORE_SOFTDROP_EN
    logic [3:0]         pending_q;
    logic               flush;
`endif

    score_base_lut u_lut (
        .lines_i  (ev_lines),
        .points_o (lut_pts),
        .valid_o  (lut_valid)
    );

    assign ev_ready  = (state_q == IDLE);
    assign accept    = ev_valid && ev_ready;
    assign lvl_clamp = (level > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : level;

`ifdef SCORE_SOFTDROP_EN
    // Soft-drop points go out only on idle cycles with no event taken
    assign flush = ev_ready && !accept && (pending_q != 4'd0);
`endif

    assign score_to_add = score_q;
    assign busy         = busy_q;
    assign award_done   = done_q;

    // Award FSM: registered increments, repeat count and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            score_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rep_q   <= '0;
`ifdef SCORE_SOFTDROP_EN
            pending_q <= 4'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    score_q <= '0;
                    busy_q  <= 1'b0;
                    if (accept && lut_valid) begin
                        state_q <= ISSUE;
                        score_q <= lut_pts;
                        busy_q  <= 1'b1;
                        rep_q   <= lvl_clamp;
                        done_q  <= (lvl_clamp == '0);
                    end
`ifdef SCORE_SOFTDROP_EN
                    else if (flush) begin
                        score_q <= bcd_score_t'(DIGIT_W'(pending_q));
                    end
`endif
                end
                ISSUE: begin
                    if (rep_q != '0) begin
                        rep_q  <= rep_q - 1'b1;
                        done_q <= (rep_q == LEVEL_W'(1));
                    end else begin
                        state_q <= IDLE;
                        score_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
`ifdef SCORE_SOFTDROP_EN
            if (flush) begin
                pending_q <= softdrop_pulse ? 4'd1 : 4'd0;
            end else if (softdrop_pulse && pending_q < 4'd9) begin
                pending_q <= pending_q + 4'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_score_event_sequencer.sv
// Self-checking bench for score_event_sequencer.
// Build option: SCORE_SOFTDROP_EN also exercises the soft-drop path.
module tb_score_event_sequencer;
    import score_pkg::*;

`ifdef SCORE_SOFTDROP_EN
    localparam bit SD_EN = 1'b1;
`else
    localparam bit SD_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               ev_valid;
    logic [2:0]         ev_lines;
    logic [LEVEL_W-1:0] level;
    logic               softdrop_pulse;
    logic               ev_ready;
    bcd_score_t         score_to_add;
    logic               busy;
    logic               award_done;

    always #5 clk = ~clk;

    score_event_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_lines       (ev_lines),
        .level          (level),
`ifdef SCORE_SOFTDROP_EN
        .softdrop_pulse (softdrop_pulse),
`endif
        .ev_ready       (ev_ready),
        .score_to_add   (score_to_add),
        .busy           (busy),
        .award_done     (award_done)
    );

    typedef struct {
        int val;
        bit done;
        bit bsy;
    } ent_t;

    typedef struct {
        int lines;
        int lvl;
        int exp_val;
        int exp_cycles;
        int exp_done;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    ent_t cur;
    int   pend;
    int   acc;
    int   nz;
    int   ndone;
    int   lastv;
    int   rdy_low;
    int   ones;
    int   nines;

    function automatic int dec(bcd_score_t s);
        return int'(s[3]) * 1000 + int'(s[2]) * 100 + int'(s[1]) * 10 + int'(s[0]);
    endfunction

    function automatic bcd_score_t to_bcd(int v);
        bcd_score_t r;
        int p;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[i] = DIGIT_W'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int base_pts(int lines);
        case (lines)
            1: return 40;
            2: return 100;
            3: return 300;
            4: return 1200;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        cur  = '{0, 1'b0, 1'b0};
        pend = 0;
    endtask

    // Advance the reference model across one rising edge
    task automatic model_step(input bit v, input int ln, input int lv, input bit p);
        bit   took;
        int   b;
        int   reps;
        ent_t e;
        took = v && !cur.bsy;
        b    = base_pts(ln);
        if (took && b >= 0) begin
            reps = ((lv > MAX_LEVEL) ? MAX_LEVEL : lv) + 1;
            for (int k = 0; k < reps; k++) q.push_back('{b, (k == reps - 1), 1'b1});
        end
        if (q.size() > 0) e = q.pop_front();
        else e = '{0, 1'b0, 1'b0};
        if (SD_EN) begin
            if (!cur.bsy && !took && pend > 0) begin
                e    = '{pend, 1'b0, 1'b0};
                pend = p ? 1 : 0;
            end else if (p) begin
                pend = (pend < 9) ? pend + 1 : 9;
            end
        end
        cur = e;
    endtask

    task automatic check_model(input string nm);
        tests++;
        if (score_to_add !== to_bcd(cur.val) || busy !== cur.bsy ||
            award_done !== cur.done || ev_ready !== !cur.bsy) begin
            fails++;
            $display("FAIL %s t=%0t: score=%0d busy=%b done=%b rdy=%b, want score=%0d busy=%b done=%b rdy=%b",
                     nm, $time, dec(score_to_add), busy, award_done, ev_ready,
                     cur.val, cur.bsy, cur.done, !cur.bsy);
        end
    endtask

    task automatic expect_int(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic clr_stats();
        nz = 0; ndone = 0; lastv = 0; rdy_low = 0; ones = 0; nines = 0; acc = 0;
    endtask

    // One clock: drive, model the edge, sample at the falling edge
    task automatic cyc(input bit v, input int ln, input int lv, input bit p, input string nm);
        int d;
        ev_valid       = v;
        ev_lines       = 3'(ln);
        level          = LEVEL_W'(lv);
        softdrop_pulse = p;
        @(posedge clk);
        model_step(v, ln, lv, p);
        @(negedge clk);
        check_model(nm);
        d   = dec(score_to_add);
        acc = (acc + d) % 10000;
        if (d != 0) begin nz++; lastv = d; end
        if (d == 1) ones++;
        if (d == 9) nines++;
        if (award_done === 1'b1) ndone++;
        if (ev_ready === 1'b0) rdy_low++;
    endtask

    task automatic do_reset();
        ev_valid = 1'b0; ev_lines = 3'd0; level = '0; softdrop_pulse = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_model("reset_state");
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1, 0, 40, 1, 1};
        vecs[1] = '{2, 0, 100, 1, 1};
        vecs[2] = '{3, 1, 300, 2, 1};
        vecs[3] = '{4, 2, 1200, 3, 1};
        vecs[4] = '{3, 12, 300, 10, 1};
        vecs[5] = '{0, 3, 0, 0, 0};
        vecs[6] = '{5, 2, 0, 0, 0};
        vecs[7] = '{7, 0, 0, 0, 0};
        vecs[8] = '{4, 9, 1200, 10, 1};
        vecs[9] = '{2, 15, 100, 10, 1};

        model_reset();
        do_reset();

        // Table of single events
        foreach (vecs[i]) begin
            clr_stats();
            cyc(1'b1, vecs[i].lines, vecs[i].lvl, 1'b0, "tbl_accept");
            repeat (11) cyc(1'b0, 0, 0, 1'b0, "tbl_idle");
            expect_int($sformatf("tbl%0d_cycles", i), nz, vecs[i].exp_cycles);
            expect_int($sformatf("tbl%0d_done", i), ndone, vecs[i].exp_done);
            expect_int($sformatf("tbl%0d_value", i), lastv, vecs[i].exp_val);
        end

        // Reset in the third issue cycle: two increments of 1200 already taken
        do_reset();
        clr_stats();
        cyc(1'b1, 4, 5, 1'b0, "abort_accept");
        cyc(1'b0, 0, 0, 1'b0, "abort_issue2");
        ev_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        expect_int("abort_score_zero", dec(score_to_add), 0);
        expect_int("abort_busy_low", int'(busy), 0);
        expect_int("abort_total", acc, 2400);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_model("abort_after_reset");

        // Level 0 latency
        clr_stats();
        cyc(1'b1, 1, 0, 1'b0, "lat_accept");
        expect_int("lat_score_n1", dec(score_to_add), 40);
        expect_int("lat_done_n1", int'(award_done), 1);
        expect_int("lat_ready_n1", int'(ev_ready), 0);
        cyc(1'b0, 0, 0, 1'b0, "lat_n2");
        expect_int("lat_ready_n2", int'(ev_ready), 1);
        expect_int("lat_score_n2", dec(score_to_add), 0);

        // Accumulated totals
        clr_stats();
        cyc(1'b1, 4, 2, 1'b0, "acc3600_accept");
        repeat (4) cyc(1'b0, 0, 0, 1'b0, "acc3600_idle");
        expect_int("acc_3600", acc, 3600);
        clr_stats();
        cyc(1'b1, 3, 12, 1'b0, "acc3000_accept");
        repeat (11) cyc(1'b0, 0, 0, 1'b0, "acc3000_idle");
        expect_int("acc_3000", acc, 3000);
        cyc(1'b1, 4, 9, 1'b0, "wrap_accept");
        repeat (11) cyc(1'b0, 0, 0, 1'b0, "wrap_idle");
        expect_int("acc_wrap_5000", acc, 5000);

        // Event held during ISSUE waits for IDLE
        clr_stats();
        cyc(1'b1, 2, 3, 1'b0, "hold_accept");
        repeat (4) cyc(1'b1, 2, 3, 1'b0, "hold_busy");
        expect_int("hold_ready_low", rdy_low, 4);
        expect_int("hold_ready_back", int'(ev_ready), 1);
        cyc(1'b1, 2, 3, 1'b0, "hold_second");
        repeat (6) cyc(1'b0, 0, 0, 1'b0, "hold_idle");
        expect_int("hold_two_awards", ndone, 2);
        clr_stats();
        cyc(1'b1, 0, 3, 1'b0, "zero_lines");
        cyc(1'b1, 5, 3, 1'b0, "five_lines");
        repeat (3) cyc(1'b0, 0, 0, 1'b0, "invalid_idle");
        expect_int("invalid_no_output", nz, 0);
        expect_int("invalid_no_done", ndone, 0);

        if (SD_EN) begin
            // Pulses during an award saturate and flush once afterwards
            do_reset();
            clr_stats();
            cyc(1'b1, 4, 9, 1'b1, "sd_accept");
            repeat (10) cyc(1'b0, 0, 0, 1'b1, "sd_busy");
            clr_stats();
            repeat (4) cyc(1'b0, 0, 0, 1'b0, "sd_flush");
            expect_int("sd_one_nine", nines, 1);
            expect_int("sd_one_output", nz, 1);
            expect_int("sd_no_done", ndone, 0);
            // Pulse coincident with a flush survives as one point
            clr_stats();
            cyc(1'b0, 0, 0, 1'b1, "sd_p1");
            cyc(1'b0, 0, 0, 1'b1, "sd_p2");
            cyc(1'b0, 0, 0, 1'b0, "sd_p3");
            cyc(1'b0, 0, 0, 1'b0, "sd_p4");
            expect_int("sd_kept_pulse", ones, 2);
        end

        // Random traffic against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 9) < 3), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
